// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared widths, frame-size select codes and the select-to-log2(W) decode.
package maxpool_pkg;
  localparam int DW = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_W8 = 3'd0;
  localparam logic [SEL_W-1:0] SEL_W16 = 3'd1;
  localparam logic [SEL_W-1:0] SEL_W32 = 3'd2;
  localparam logic [SEL_W-1:0] SEL_W64 = 3'd3;
  localparam logic [SEL_W-1:0] SEL_W128 = 3'd4;
  localparam logic [SEL_W-1:0] SEL_W256 = 3'd5;
  function automatic logic [3:0] sel2log(input logic [SEL_W-1:0] s);
    return (s > SEL_W256) ? 4'd3 : 4'd3 + {1'b0, s};
  endfunction
endpackage

// File: rtl/maxpool_2x2_win_ctrl_if.sv
// maxpool_2x2_win_ctrl_if: window-in / pooled-out bus; master drives windows, slave is the pooler.
interface maxpool_2x2_win_ctrl_if;
  import maxpool_pkg::*;
  logic [SEL_W-1:0] sel;
  logic stride2;
  logic win_valid;
  logic [4*DW-1:0] ifm_win2x2_batch;
  logic [DW-1:0] ofm_out;
  logic ofm_valid;
  logic frame_done;
  modport master(output sel, stride2, win_valid, ifm_win2x2_batch, input ofm_out, ofm_valid, frame_done);
  modport slave(input sel, stride2, win_valid, ifm_win2x2_batch, output ofm_out, ofm_valid, frame_done);
endinterface

// File: rtl/maxpool_2x2_win_ctrl_com_max2.sv
// com_max2: combinational two-input max; signed compare when MAXPOOL_SIGNED_EN is defined.
module com_max2 #(parameter int DW = 8) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y
);
`ifdef MAXPOOL_SIGNED_EN
  assign o_y = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
`else
  assign o_y = (i_a > i_b) ? i_a : i_b;
`endif
endmodule

// File: rtl/maxpool_2x2_win_ctrl.sv
// maxpool_2x2_win_ctrl: frame position tracking, stride qualification and 2-stage 2x2 max pool.
// Build option MAXPOOL_SIGNED_EN selects signed comparisons (handled in com_max2).
module maxpool_2x2_win_ctrl
  import maxpool_pkg::*;
(
  input logic clk,
  input logic rst,
  maxpool_2x2_win_ctrl_if.slave s
);
  logic [7:0] r_col, r_row;
  logic [3:0] r_lw;
  logic r_s2;
  logic [DW-1:0] r_m0, r_m1;
  logic r_v1, r_last1;
  logic w_first, w_s2, w_lc, w_lr, w_q;
  logic [3:0] w_lw;
  logic [7:0] w_wm1;
  logic [DW-1:0] w_m0, w_m1, w_m;
  // the first pixel of a frame already runs under the config it latches
  always_comb begin
    w_first = s.win_valid && r_col == 8'd0 && r_row == 8'd0;
    w_lw = w_first ? sel2log(s.sel) : r_lw;
    w_s2 = w_first ? s.stride2 : r_s2;
    w_wm1 = 8'((9'd1 << w_lw) - 9'd1);
    w_lc = r_col == w_wm1;
    w_lr = r_row == w_wm1;
    w_q = s.win_valid && (w_s2 ? (r_row[0] && r_col[0]) : (r_row != 8'd0 && r_col != 8'd0));
  end
  com_max2 #(.DW(DW)) u_m0 (.i_a(s.ifm_win2x2_batch[DW-1:0]), .i_b(s.ifm_win2x2_batch[2*DW-1:DW]), .o_y(w_m0));
  com_max2 #(.DW(DW)) u_m1 (.i_a(s.ifm_win2x2_batch[3*DW-1:2*DW]), .i_b(s.ifm_win2x2_batch[4*DW-1:3*DW]), .o_y(w_m1));
  com_max2 #(.DW(DW)) u_m2 (.i_a(r_m0), .i_b(r_m1), .o_y(w_m));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_lw <= 4'd3;
      r_s2 <= 1'b1;
    end else begin
      if (w_first) begin
        r_lw <= w_lw;
        r_s2 <= w_s2;
      end
      if (s.win_valid) begin
        r_col <= w_lc ? 8'd0 : r_col + 8'd1;
        if (w_lc) r_row <= w_lr ? 8'd0 : r_row + 8'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0 <= '0;
      r_m1 <= '0;
      r_v1 <= 1'b0;
      r_last1 <= 1'b0;
      s.ofm_out <= '0;
      s.ofm_valid <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      r_m0 <= w_m0;
      r_m1 <= w_m1;
      r_v1 <= w_q;
      r_last1 <= s.win_valid && w_lc && w_lr;
      if (r_v1) s.ofm_out <= w_m;
      s.ofm_valid <= r_v1;
      s.frame_done <= r_v1 && r_last1;
    end
  end
endmodule

// File: tb/tb_maxpool_2x2_win_ctrl.sv
// tb_maxpool_2x2_win_ctrl: directed frames checked cycle-by-cycle against a frame-level pooling model.
module tb_maxpool_2x2_win_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int n_fd = 0;
  logic [7:0] obs[1024];
  typedef struct packed {int due; logic [7:0] val; logic last;} exp_t;
  exp_t q[$];
  int m_p = 0, m_w = 8, m_nq = 0;
  logic m_s2 = 1'b1;
  maxpool_2x2_win_ctrl_if bus();
  maxpool_2x2_win_ctrl dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask
  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction
  function automatic logic [31:0] win(input int k);
    return {8'(4 + k), 8'(3 + k), 8'(2 + k), 8'(1 + k)};
  endfunction
  function automatic int wdec(input logic [2:0] s);
    return (s > 3'd5) ? 8 : (8 << s);
  endfunction
  // frame-level model: pixel index -> (row, col), qualified outputs counted against the frame total
  task automatic px(input logic v, input logic [31:0] d, input logic [2:0] s, input logic st);
    int r, c, tot;
    @(posedge clk);
    #1;
    bus.win_valid = v;
    bus.ifm_win2x2_batch = d;
    bus.sel = s;
    bus.stride2 = st;
    if (v) begin
      if (m_p == 0) begin
        m_w = wdec(s);
        m_s2 = st;
        m_nq = 0;
      end
      r = m_p / m_w;
      c = m_p % m_w;
      tot = m_s2 ? (m_w / 2) * (m_w / 2) : (m_w - 1) * (m_w - 1);
      if (m_s2 ? (r % 2 == 1 && c % 2 == 1) : (r >= 1 && c >= 1)) begin
        m_nq++;
        q.push_back('{cyc + 2, mx(mx(d[7:0], d[15:8]), mx(d[23:16], d[31:24])), m_nq == tot});
      end
      m_p = (m_p + 1 == m_w * m_w) ? 0 : m_p + 1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) px(1'b0, 32'h0, bus.sel, bus.stride2);
  endtask
  task automatic frame(input logic [2:0] s, input logic st, input int gap, input int chg, input logic [2:0] s2nd);
    int w;
    w = wdec(s);
    for (int p = 0; p < w * w; p++) begin
      px(1'b1, win(p), (p >= chg) ? s2nd : s, st);
      idle(gap);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      check("ofm_valid", int'(bus.ofm_valid), 1);
      check("ofm_out", int'(bus.ofm_out), int'(q[0].val));
      check("frame_done", int'(bus.frame_done), int'(q[0].last));
      void'(q.pop_front());
    end else begin
      check("idle_valid", int'(bus.ofm_valid), 0);
      check("idle_frame_done", int'(bus.frame_done), 0);
    end
    if (bus.ofm_valid) begin
      obs[n_out % 1024] = bus.ofm_out;
      n_out++;
    end
    if (bus.frame_done) n_fd++;
  end
  initial begin
    int b, f;
    bus.win_valid = 1'b0;
    bus.ifm_win2x2_batch = '0;
    bus.sel = 3'd0;
    bus.stride2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ofm_out", int'(bus.ofm_out), 0);
    check("rst_ofm_valid", int'(bus.ofm_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst = 1'b0;
    b = n_out; f = n_fd;
    frame(3'd0, 1'b1, 0, 1 << 30, 3'd0);
    idle(4);
    check("s2_count", n_out - b, 16);
    check("s2_first", int'(obs[b]), 13);
    check("s2_last", int'(obs[b + 15]), 67);
    check("s2_fd", n_fd - f, 1);
    b = n_out; f = n_fd;
    frame(3'd0, 1'b0, 0, 1 << 30, 3'd0);
    idle(4);
    check("s1_count", n_out - b, 49);
    check("s1_first", int'(obs[b]), 13);
    check("s1_fd", n_fd - f, 1);
    b = n_out;
    frame(3'd0, 1'b1, 1, 1 << 30, 3'd0);
    idle(4);
    check("gap_count", n_out - b, 16);
    check("gap_first", int'(obs[b]), 13);
    check("gap_last", int'(obs[b + 15]), 67);
    b = n_out;
    for (int p = 0; p < 64; p++) px(1'b1, (p == 9) ? 32'h8001_7F00 : win(p), 3'd0, 1'b1);
    idle(4);
`ifdef MAXPOOL_SIGNED_EN
    check("signed_max", int'(obs[b]), 8'h7F);
`else
    check("unsigned_max", int'(obs[b]), 8'h80);
`endif
    b = n_out;
    frame(3'd0, 1'b1, 0, 20, 3'd1);
    idle(4);
    check("selchg_w8_count", n_out - b, 16);
    b = n_out; f = n_fd;
    frame(3'd1, 1'b1, 0, 1 << 30, 3'd1);
    idle(4);
    check("w16_count", n_out - b, 64);
    check("w16_fd", n_fd - f, 1);
    b = n_out;
    frame(3'd0, 1'b1, 0, 1 << 30, 3'd0);
    frame(3'd0, 1'b0, 0, 1 << 30, 3'd0);
    idle(4);
    check("b2b_count", n_out - b, 65);
    b = n_out;
    for (int p = 0; p < 10; p++) px(1'b1, win(p), 3'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.win_valid = 1'b0;
    q.delete();
    m_p = 0;
    @(posedge clk);
    #1;
    check("midrst_ofm_out", int'(bus.ofm_out), 0);
    check("midrst_ofm_valid", int'(bus.ofm_valid), 0);
    rst = 1'b0;
    idle(3);
    check("midrst_discard", n_out - b, 0);
    b = n_out; f = n_fd;
    frame(3'd0, 1'b1, 0, 1 << 30, 3'd0);
    idle(4);
    check("post_rst_count", n_out - b, 16);
    check("post_rst_first", int'(obs[b]), 13);
    check("post_rst_fd", n_fd - f, 1);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2_win_ctrl.md
Name: maxpool_2x2_win_ctrl

Overview:
- Consumes the 32-bit 2x2 window stream from the 2x2 line buffer and emits one max-pooled activation per valid window position.
- Tracks row/column position inside a square frame, decimates windows for stride 2 or passes all interior windows for stride 1, and computes the 4-way max in a 2-stage pipeline.
- Sits directly downstream of the 2x2 line buffer in the YOLOv3-Tiny maxpool path, feeding the output feature-map writer.

Parameters:
- DW, 8, activation width in bits; the window input is 4*DW.
- SEL_W, 3, width of the frame-size select.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sel  in  3  frame-size select: W = 8<<sel for sel 0..5 (8..256); 6 and 7 are reserved and decode as W=8
- stride2  in  1  1 = stride 2, 0 = stride 1
- win_valid  in  1  window on ifm_win2x2_batch is valid this cycle; asserted once per input pixel, aligned with the window
- ifm_win2x2_batch  in  32  [7:0]=row0 col0, [15:8]=row0 col1, [23:16]=row1 col0, [31:24]=row1 col1 (col1 and row1 are newest)
- ofm_out  out  8  pooled activation
- ofm_valid  out  1  ofm_out valid
- frame_done  out  1  one-cycle pulse coincident with the last ofm_valid of a frame

Behaviour:
- Reset (async, rst=1): col=0, row=0, all pipeline valids=0, ofm_out=0, ofm_valid=0, frame_done=0, latched W=8, latched stride2=1.
- Config latch: sel and stride2 are sampled on a win_valid with col=0 and row=0 (first pixel of a frame). Changes mid-frame are ignored until the next frame start.
- Counters: each win_valid advances col. At col=W-1, col wraps to 0 and row increments. At row=W-1 and col=W-1, both wrap to 0 (end of frame). Cycles with win_valid=0 hold both counters.
- Window qualification for the pixel at (row, col), with the window covering rows row-1..row and cols col-1..col:
  - stride2=1: qualify when row[0]=1 and col[0]=1, giving (W/2)^2 outputs.
  - stride2=0: qualify when row>=1 and col>=1, giving (W-1)^2 outputs.
- Pipeline: stage 1 registers m0=max(b0,b1), m1=max(b2,b3) and v1=qualify. Stage 2 registers ofm_out=max(m0,m1), ofm_valid=v1, frame_done=v1 & last1, where last1 marks the registered end-of-frame position.
- Latency: 2 clk from a qualified win_valid to ofm_valid. Throughput is 1 output per clk; there is no back-pressure.
- Compare: unsigned DW-bit by default. Equal operands select either (result identical).
- ofm_out holds its last value when ofm_valid=0.
- Boundary cases:
  - Consecutive frames with no gap: the counters wrap and the next pixel is (0,0), with fresh config latch in the same cycle.
  - rst mid-frame: counters and pipeline clear immediately; in-flight results are discarded with no ofm_valid or frame_done.
  - W=8, stride 1: frame_done on output #49.

Optional Feature:
- MAXPOOL_SIGNED_EN: when defined, all comparisons are two's-complement signed DW-bit, for leaky-ReLU activations. When undefined, comparisons are unsigned.
- Latency and control are identical in both builds.

Decomposition:
- Shared package maxpool_pkg:
  - DW default and the sel-to-width decode function (sel to log2 W, reserved codes map to 3).
  - Constants SEL_W8..SEL_W256.
- Sub-module com_max2: a combinational two-input max honouring MAXPOOL_SIGNED_EN. It is instantiated three times (two in stage 1, one in stage 2).
- The counter, qualify logic and pipeline registers live in the top module.

Test Plan:
- Reset, then sel=0, stride2=1, 64 contiguous win_valid with window bytes {b3,b2,b1,b0}={4,3,2,1}+k -> exactly 16 ofm_valid, each ofm_out = byte3 of the qualifying window, 2-clk latency; frame_done only with the 16th.
- sel=0, stride2=0, 64 pixels -> 49 outputs, the first on pixel (1,1); frame_done on the 49th.
- win_valid toggled 1-0-1-0 over a sel=0, stride2=1 frame -> same 16 results as contiguous; counters hold on idle cycles.
- Window 0x80_01_7F_00: default build gives 0x80; MAXPOOL_SIGNED_EN build gives 0x7F.
- sel changed from 0 to 1 at pixel 20 of a W=8 frame -> frame completes as W=8 with 16 outputs; the next frame runs W=16 with 64 outputs.
- rst pulsed 1 clk after a qualified window -> no ofm_valid follows; ofm_out=0; the next frame starts at (0,0) with the correct count.
